// File: rtl/aes256_key_expander_if.sv
// Key, S-box and round-key signals of the AES-256 key expander. Word 0 of a key and byte 0 of a
// word sit in the most significant bits.
interface aes256_key_expander_if;
  logic         key_valid;
  logic [255:0] key_in;
  logic         key_ready;
  logic         sbox_ready;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic         rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         rk_last;

  // Expander side.
  modport slave (
    input  key_valid, key_in, sbox_ready, sub_out,
    output key_ready, sub_in, rk_valid, rk_idx, rk_out, rk_last
  );

  // Key source, S-box and round-key consumer side.
  modport master (
    output key_valid, key_in, sbox_ready, sub_out,
    input  key_ready, sub_in, rk_valid, rk_idx, rk_out, rk_last
  );
endinterface

// File: rtl/aes256_key_expander.sv
// Sequential AES-256 key schedule: one word per step through an 8-word sliding window, sharing
// an external subWord stage, emitting each 128-bit round key as a one-cycle pulse.
module aes256_key_expander #(
  parameter int unsigned SUB_LAT = 1
) (
  input logic                   clk,
  input logic                   reset,
  aes256_key_expander_if.slave  bus
);

  localparam int unsigned CntW = (SUB_LAT > 1) ? $clog2(SUB_LAT) : 1;

  typedef enum logic [2:0] {
    StIdle, StEmit0, StEmit1, StSub, StWait, StXor, StDone
  } state_e;

  state_e          state_q;
  logic [31:0]     win_q [8];
  logic [5:0]      idx_q;
  logic [CntW-1:0] wait_q;
  logic            pend_q;
  logic [31:0]     sub_hold_q;
  logic            rk_valid_q;
  logic [3:0]      rk_idx_q;
  logic [127:0]    rk_out_q;
  logic            rk_last_q;

  logic [31:0] sub_sel;
  logic [31:0] new_word;
  logic [7:0]  rcon;
  logic        key_ready;
  logic        shift_en;

  always_comb begin
    sub_sel  = idx_q[2] ? win_q[7] : {win_q[7][23:0], win_q[7][31:24]};
    rcon     = 8'h01 << (idx_q[5:3] - 3'd1);
    key_ready = (state_q == StIdle) && bus.sbox_ready;
    shift_en = ((state_q == StWait) && (wait_q == '0)) ||
               ((state_q == StXor) && (idx_q != 6'd60));
    new_word = win_q[0] ^ win_q[7];
    if (state_q == StWait) begin
      new_word = win_q[0] ^ bus.sub_out;
      if (!idx_q[2]) begin
        new_word = new_word ^ {rcon, 24'h0};
      end
    end
  end

  // S-box input follows the window only while the request is launched, then holds.
  assign bus.sub_in    = (state_q == StSub) ? sub_sel : sub_hold_q;
  assign bus.key_ready = key_ready;
  assign bus.rk_valid  = rk_valid_q;
  assign bus.rk_idx    = rk_idx_q;
  assign bus.rk_out    = rk_out_q;
  assign bus.rk_last   = rk_last_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      for (int k = 0; k < 8; k++) begin
        win_q[k] <= '0;
      end
      idx_q      <= '0;
      wait_q     <= '0;
      pend_q     <= 1'b0;
      sub_hold_q <= '0;
      rk_valid_q <= 1'b0;
      rk_idx_q   <= '0;
      rk_out_q   <= '0;
      rk_last_q  <= 1'b0;
    end else begin
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
      pend_q     <= 1'b0;

      // A group completed last cycle; the window still holds it.
      if (pend_q) begin
        rk_valid_q <= 1'b1;
        rk_idx_q   <= idx_q[5:2] - 4'd1;
        rk_out_q   <= {win_q[4], win_q[5], win_q[6], win_q[7]};
        rk_last_q  <= (idx_q == 6'd60);
      end

      if (shift_en) begin
        for (int k = 0; k < 7; k++) begin
          win_q[k] <= win_q[k+1];
        end
        win_q[7] <= new_word;
        idx_q    <= idx_q + 6'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (bus.key_valid && key_ready) begin
            for (int k = 0; k < 8; k++) begin
              win_q[k] <= bus.key_in[255-32*k -: 32];
            end
            idx_q   <= 6'd8;
            state_q <= StEmit0;
          end
        end
        StEmit0: begin
          rk_valid_q <= 1'b1;
          rk_idx_q   <= 4'd0;
          rk_out_q   <= {win_q[0], win_q[1], win_q[2], win_q[3]};
          state_q    <= StEmit1;
        end
        StEmit1: begin
          rk_valid_q <= 1'b1;
          rk_idx_q   <= 4'd1;
          rk_out_q   <= {win_q[4], win_q[5], win_q[6], win_q[7]};
          state_q    <= StSub;
        end
        StSub: begin
          sub_hold_q <= sub_sel;
          wait_q     <= CntW'(SUB_LAT - 1);
          state_q    <= StWait;
        end
        StWait: begin
          if (wait_q == '0) begin
            state_q <= StXor;
          end else begin
            wait_q <= wait_q - CntW'(1);
          end
        end
        StXor: begin
          // At i==60 this cycle only lets the final round key out before DONE.
          if (idx_q == 6'd60) begin
            state_q <= StDone;
          end else if (idx_q[1:0] == 2'd3) begin
            pend_q  <= 1'b1;
            state_q <= (idx_q == 6'd59) ? StXor : StSub;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_key_expander.sv
// Directed bench for aes256_key_expander: FIPS-197 A.3 and zero-key schedules, S-box gating,
// ignored and back-to-back keys, mid-schedule reset, and a three-cycle S-box latency.
module tb_aes256_key_expander;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [255:0] KEY_A3 =
    256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
  localparam logic [255:0] KEY_C =
    256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
  localparam logic [255:0] KEY_D =
    256'hdeadbeef_01234567_89abcdef_fedcba98_76543210_0badf00d_cafef00d_a5a55a5a;
  localparam logic [127:0] RK2_A3  = 128'h9ba35411_8e6925af_a51a8b5f_2067fcde;
  localparam logic [127:0] RK14_A3 = 128'hfe4890d1_e6188d0b_046df344_706c631e;
  localparam logic [127:0] RK2_Z   = 128'h62636363_62636363_62636363_62636363;
  localparam logic [127:0] RK3_Z   = 128'haafbfbfb_aafbfbfb_aafbfbfb_aafbfbfb;

  typedef struct packed {
    int           cyc;
    logic [3:0]   idx;
    logic [127:0] rk;
    logic         last;
  } pulse_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;

  pulse_t p1 [64];
  pulse_t p3 [64];
  int     n1 = 0;
  int     n3 = 0;
  int     nacc1 = 0;
  int     nacc3 = 0;

  logic [31:0] s3a, s3b;

  aes256_key_expander_if bus1 ();
  aes256_key_expander_if bus3 ();

  aes256_key_expander #(.SUB_LAT(1)) u_dut1 (.clk(clk), .reset(rst_n), .bus(bus1));
  aes256_key_expander #(.SUB_LAT(3)) u_dut3 (.clk(clk), .reset(rst_n), .bus(bus3));

  always #5 clk = ~clk;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [2047:0] t;
    t = SBOX;
    return t[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [127:0] ref_rk(input logic [255:0] key, input int k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int j = 0; j < 8; j++) w[j] = key[255-32*j -: 32];
    rc = 8'h01;
    for (int j = 8; j < 60; j++) begin
      t = w[j-1];
      if (j % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0};
      end else if (j % 8 == 4) begin
        t = sub_word(t);
      end
      w[j] = w[j-8] ^ t;
    end
    return {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endfunction

  // S-box models: one registered stage, and a three-stage delayed read.
  always @(posedge clk) begin
    bus1.sub_out <= sub_word(bus1.sub_in);
    s3a          <= sub_word(bus3.sub_in);
    s3b          <= s3a;
    bus3.sub_out <= s3b;
    cyc          <= cyc + 1;
  end

  always @(negedge clk) begin
    if (bus1.key_valid === 1'b1 && bus1.key_ready === 1'b1) nacc1 <= nacc1 + 1;
    if (bus3.key_valid === 1'b1 && bus3.key_ready === 1'b1) nacc3 <= nacc3 + 1;
    if (bus1.rk_valid === 1'b1 && n1 < 64) begin
      p1[n1] <= '{cyc, bus1.rk_idx, bus1.rk_out, bus1.rk_last};
      n1     <= n1 + 1;
    end
    if (bus3.rk_valid === 1'b1 && n3 < 64) begin
      p3[n3] <= '{cyc, bus3.rk_idx, bus3.rk_out, bus3.rk_last};
      n3     <= n3 + 1;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic goto_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compares cnt captured pulses from index base against the reference schedule and timing.
  task automatic check_sched(input int which, input logic [255:0] key, input int acc,
                             input int lat, input int base, input int cnt);
    pulse_t p;
    int     ec;
    for (int k = 0; k < cnt; k++) begin
      p  = (which == 1) ? p1[base+k] : p3[base+k];
      ec = (k < 2) ? acc + k + 1 : acc + 3 + (4 + lat) * (k - 1);
      check($sformatf("d%0d_idx%0d", which, k), p.idx, k);
      check($sformatf("d%0d_rk%0d", which, k), p.rk, ref_rk(key, k));
      check($sformatf("d%0d_last%0d", which, k), p.last, k == 14);
      check($sformatf("d%0d_cyc%0d", which, k), p.cyc, ec);
    end
  endtask

  int a0, a2, a3, a4;

  initial begin
    #100000;
    $display("FAIL watchdog: cycle=%0d limit reached", cyc);
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b0;
    bus1.key_valid  = 1'b1;
    bus1.key_in     = KEY_A3;
    bus1.sbox_ready = 1'b0;
    bus3.key_valid  = 1'b0;
    bus3.key_in     = KEY_A3;
    bus3.sbox_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    check("rst_valid", bus1.rk_valid, 0);
    check("rst_out", bus1.rk_out, 0);
    check("rst_idx", bus1.rk_idx, 0);
    check("rst_last", bus1.rk_last, 0);
    check("rst_subin", bus1.sub_in, 0);
    check("rst_kready", bus1.key_ready, 0);
    check("rst_kready3", bus3.key_ready, 1);

    // Key offered while the S-box is still initialising must wait.
    goto_cyc(cyc + 4);
    check("nosbox_rk", n1, 0);
    check("nosbox_acc", nacc1, 0);
    check("nosbox_kready", bus1.key_ready, 0);

    bus1.sbox_ready = 1'b1;
    #1;
    check("sbox_kready", bus1.key_ready, 1);
    a0 = cyc + 1;

    // A different key offered mid-schedule is ignored, then taken back-to-back.
    goto_cyc(a0 + 10);
    check("busy_kready", bus1.key_ready, 0);
    bus1.key_in = '0;
    goto_cyc(a0 + 69);
    check("b2b_kready", bus1.key_ready, 1);
    goto_cyc(a0 + 70);
    bus1.key_valid = 1'b0;
    goto_cyc(a0 + 70 + 72);

    check("a3z_npulse", n1, 30);
    check("a3z_nacc", nacc1, 2);
    check("a3_rk2", p1[2].rk, RK2_A3);
    check("a3_rk2_cyc", p1[2].cyc, a0 + 8);
    check("a3_rk14", p1[14].rk, RK14_A3);
    check("a3_rk14_cyc", p1[14].cyc, a0 + 68);
    check("a3_rk14_last", p1[14].last, 1);
    check("z_rk0_cyc", p1[15].cyc, a0 + 71);
    check("z_rk2", p1[17].rk, RK2_Z);
    check("z_rk3", p1[18].rk, RK3_Z);
    check_sched(1, KEY_A3, a0, 1, 0, 15);
    check_sched(1, '0, a0 + 70, 1, 15, 15);

    // Reset one cycle at cycle 30 of a schedule aborts it.
    bus1.key_in    = KEY_C;
    bus1.key_valid = 1'b1;
    a2 = cyc + 1;
    goto_cyc(a2);
    bus1.key_valid = 1'b0;
    goto_cyc(a2 + 29);
    rst_n = 1'b0;
    goto_cyc(a2 + 30);
    rst_n = 1'b1;
    check("abort_valid", bus1.rk_valid, 0);
    check("abort_out", bus1.rk_out, 0);
    check("abort_idx", bus1.rk_idx, 0);
    check("abort_last", bus1.rk_last, 0);
    check("abort_subin", bus1.sub_in, 0);
    check("abort_kready", bus1.key_ready, 1);
    goto_cyc(a2 + 40);
    check("abort_npulse", n1, 37);
    check_sched(1, KEY_C, a2, 1, 30, 7);

    bus1.key_in    = KEY_D;
    bus1.key_valid = 1'b1;
    a3 = cyc + 1;
    goto_cyc(a3);
    bus1.key_valid = 1'b0;
    goto_cyc(a3 + 72);
    check("d_npulse", n1, 52);
    check_sched(1, KEY_D, a3, 1, 37, 15);

    // Three-cycle S-box latency stretches each group by two cycles.
    bus3.key_valid = 1'b1;
    a4 = cyc + 1;
    goto_cyc(a4);
    bus3.key_valid = 1'b0;
    goto_cyc(a4 + 100);
    check("l3_npulse", n3, 15);
    check("l3_nacc", nacc3, 1);
    check("l3_rk2", p3[2].rk, RK2_A3);
    check("l3_rk2_cyc", p3[2].cyc, a4 + 10);
    check("l3_rk14", p3[14].rk, RK14_A3);
    check("l3_rk14_cyc", p3[14].cyc, a4 + 94);
    check_sched(3, KEY_A3, a4, 3, 0, 15);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/aes256_key_expander.md
# aes256_key_expander

Sequential AES-256 key schedule generator that sits directly upstream of the `subWord` S-box stage and consumes its output. It accepts a 256-bit cipher key and walks FIPS-197 words w[8]..w[59] one word per step. For every word with index i%4==0, it drives the shared `subWord` instance (`sub_in` → `sub_out`). Each completed 128-bit round key (indices 0..14) is emitted as a one-cycle pulse for the pipelined round stages.

## Interface
- `SUB_LAT`, default 1: cycles from `sub_in` presented to `sub_out` valid (registered S-box RAM read).
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `key_valid`  in  1  key offer; accepted on a cycle with `key_valid & key_ready`.
- `key_in`  in  [0:255]  cipher key, w0 = bits 0:31 … w7 = bits 224:255; byte 0 of a word = bits 0:7.
- `sbox_ready`  in  1  from `subWord.s_box_ready`; S-box RAM initialised.
- `sub_out`  in  [0:31]  from `subWord.out_data`.
- `sub_in`  out  [0:31]  to `subWord.in_data`.
- `key_ready`  out  1  high only in IDLE with `sbox_ready`=1.
- `rk_valid`  out  1  one-cycle pulse per round key.
- `rk_idx`  out  [3:0]  round key index 0..14, valid with `rk_valid`.
- `rk_out`  out  [0:127]  round key {w[4k], w[4k+1], w[4k+2], w[4k+3]}.
- `rk_last`  out  1  high with `rk_valid` when `rk_idx`=14.

## Operation
- State is held in an 8-word sliding window W[0..7] (W[7] = w[i-1], W[0] = w[i-8]), a word index i (6 bits, 8..59), a wait counter, and the FSM.
- **FSM states:** IDLE, EMIT0, EMIT1, SUB, WAIT, XOR, DONE.
- **IDLE:** `key_ready` = `sbox_ready`.
  - On accept: load the window from `key_in`, set i=8, go to EMIT0.
  - `key_valid` is ignored in every state other than IDLE.
- **EMIT0 / EMIT1:** pulse rk 0 (w0..3), then rk 1 (w4..7). Go to SUB.
- **SUB** (i%4==0):
  - If i%8==0: `sub_in` = RotWord(w[i-1]) = {b1,b2,b3,b0}.
  - If i%8==4: `sub_in` = w[i-1].
  - Go to WAIT.
- **WAIT:** hold `sub_in` for SUB_LAT cycles. On the last cycle, compute the new word:
  - i%8==0: w[i] = w[i-8] ^ sub_out ^ {Rcon[i/8], 24'h0}.
  - i%8==4: w[i] = w[i-8] ^ sub_out.
  - Shift the new word into the window, i++, go to XOR.
- **XOR:** w[i] = w[i-8] ^ w[i-1], one word per cycle, for the 3 words where i%4≠0. Shift and i++ each cycle.
  - After the 4th word of a group: the next cycle pulses `rk_valid` with `rk_out` = W[4..7] and `rk_idx` = i/4−1.
  - Then go to SUB, or to DONE if i==60.
- **Rcon:** 8'h01, 02, 04, 08, 10, 20, 40 for i/8 = 1..7, XORed into byte 0 (bits 0:7).
- **DONE:** one cycle, then back to IDLE. `rk_last` accompanies rk 14 (asserted before DONE).
- **No backpressure:** the consumer must capture each pulse.
- **Reset values:** all outputs 0, `sub_in` = 0, FSM = IDLE, window cleared.
  - Reset mid-operation aborts the schedule; no further `rk_valid` until a new key is accepted.
- **`sbox_ready` deasserting while busy:** not legal (the S-box only initialises after reset). The FSM does not check it.
- `sub_in` holds its last value outside SUB/WAIT. The `subWord` output is only sampled in WAIT.

## Timing
- Accept edge = cycle 0.
  - rk 0 valid in cycle 1; rk 1 valid in cycle 2.
  - For k≥2: rk k valid in cycle 3+(4+SUB_LAT)(k−1). With SUB_LAT=1: rk 2 at cycle 8, rk 14 at cycle 68.
- `rk_valid` is never high in two consecutive cycles after rk 1.
- `key_ready` rises again at cycle 70 (SUB_LAT=1), two cycles after rk 14.
  - A key held valid at that point is accepted immediately (back-to-back keys).
- All outputs are registered except `key_ready` and `sub_in`, which are decoded from FSM state and window.

## Test plan
- **FIPS-197 A.3 key** 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4, SUB_LAT=1:
  - rk 2 = 9ba35411 8e6925af a51a8b5f 2067fcde at cycle 8.
  - rk 14 = fe4890d1 e6188d0b 046df344 706c631e at cycle 68 with `rk_last`=1.
  - Exactly 15 pulses, idx 0..14 in order.
- **Key of all zeros:**
  - rk 2 = 62636363 62636363 62636363 62636363.
  - rk 3 = aafbfbfb aafbfbfb aafbfbfb aafbfbfb.
- **`sbox_ready`=0 after reset with `key_valid`=1:** `key_ready`=0 and no `rk_valid`. Raise `sbox_ready` → accept in that cycle, rk 0 one cycle later.
- **Second `key_valid` with a different key during cycles 10..60:** ignored; all rk values match the first key. A key held at cycle 70 is accepted and its rk 0 appears at cycle 71.
- **`reset`=0 at cycle 30 for 1 cycle:** all outputs 0 the next cycle, `key_ready`=1, no stray `rk_valid`. A new key then produces a correct full schedule.
- **SUB_LAT=3 with a delayed S-box model:** rk 2 at cycle 10 and rk 14 at cycle 94, with A.3 values unchanged.
